// File: rtl/lfsr_pattern_ctrl_if.sv
// ---------------------------------------------------------------------------
// lfsr_pattern_ctrl_if
// Request/status bundle between a controller (master) and the LFSR pattern
// player (slave).
//   i_Start   master->slave  seed the LFSR, generate a new pattern, play it
//   i_Replay  master->slave  play the stored pattern again
//   i_Seed    master->slave  4-bit LFSR seed, sampled with i_Start
//   i_Len     master->slave  5-bit requested length, sampled with i_Start
//   o_Busy    slave->master  high whenever the player is not idle
//   o_Led     slave->master  one-hot LED drive while an entry is shown
//   o_Number  slave->master  current LFSR register value
//   o_Done    slave->master  one-cycle pulse when playback finishes
// ---------------------------------------------------------------------------
interface lfsr_pattern_ctrl_if;
    logic       i_Start;
    logic       i_Replay;
    logic [3:0] i_Seed;
    logic [4:0] i_Len;
    logic       o_Busy;
    logic [3:0] o_Led;
    logic [3:0] o_Number;
    logic       o_Done;

    modport master (
        output i_Start, i_Replay, i_Seed, i_Len,
        input  o_Busy, o_Led, o_Number, o_Done
    );

    modport slave (
        input  i_Start, i_Replay, i_Seed, i_Len,
        output o_Busy, o_Led, o_Number, o_Done
    );
endinterface

// File: rtl/lfsr_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_pattern_ctrl
// Generates a pseudo-random sequence of LED positions with a 4-bit LFSR,
// stores it, and plays it back: each entry lights one LED for ON_CYCLES
// cycles followed by an all-dark gap of OFF_CYCLES cycles. A stored pattern
// can be replayed without regenerating it.
// Ports:
//   i_Clk    system clock, all state changes on the rising edge
//   i_Reset  synchronous active-high reset
//   bus      lfsr_pattern_ctrl_if.slave (start/replay requests, seed,
//            length, busy/led/number/done status)
// Parameters:
//   MAX_LEN     maximum pattern length in entries
//   ON_CYCLES   cycles each pattern LED is lit (>= 1)
//   OFF_CYCLES  cycles of dark gap after each entry (>= 1)
// ---------------------------------------------------------------------------
module lfsr_pattern_ctrl #(
    parameter int MAX_LEN    = 16,
    parameter int ON_CYCLES  = 12500000,
    parameter int OFF_CYCLES = 2500000
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    lfsr_pattern_ctrl_if.slave    bus
);

    // Entry index width: index and count only ever range over 0..MAX_LEN-1.
    localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    // Phase timer counts down from (cycles-1) to 0.
    localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [IW-1:0] I_ONE    = IW'(1);
    localparam logic [IW-1:0] I_MAX    = IW'(MAX_LEN - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        GEN  = 3'd2,
        SHOW = 3'd3,
        GAP  = 3'd4,
        DONE = 3'd5
    } state_t;

    function automatic logic [3:0] lfsr_step(input logic [3:0] q);
        return {q[2:0], q[3] ^ q[2]};
    endfunction

    function automatic logic [3:0] led_of(input logic [1:0] v);
        return 4'b0001 << v;
    endfunction

    state_t          state_reg;
    logic [3:0]      lfsr_reg;
    logic [3:0]      seed_reg;
    logic [IW-1:0]   len_m1_reg;   // effective length minus one
    logic [IW-1:0]   count_reg;
    logic [IW-1:0]   index_reg;
    logic [TW-1:0]   timer_reg;
    logic            valid_reg;
    logic [3:0]      led_reg;
    logic            busy_reg;
    logic            done_reg;

    logic [1:0]      mem [MAX_LEN];
    logic            mem_we;

    assign mem_we = (state_reg == GEN) && !i_Reset;

    // Pattern store: written one entry per GEN cycle, never reset so a
    // completed pattern survives in IDLE for replay.
    always_ff @(posedge i_Clk) begin
        if (mem_we) begin
            mem[count_reg] <= lfsr_reg[1:0];
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_reg  <= IDLE;
            lfsr_reg   <= 4'b0001;
            seed_reg   <= 4'b0001;
            len_m1_reg <= '0;
            count_reg  <= '0;
            index_reg  <= '0;
            timer_reg  <= '0;
            valid_reg  <= 1'b0;
            led_reg    <= 4'b0000;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.i_Start) begin
                        // An all-zero seed would lock the LFSR up.
                        seed_reg <= (bus.i_Seed == 4'b0000) ? 4'b0001 : bus.i_Seed;
                        if (bus.i_Len == 5'd0) begin
                            len_m1_reg <= '0;
                        end else if (int'(bus.i_Len) > MAX_LEN) begin
                            len_m1_reg <= I_MAX;
                        end else begin
                            len_m1_reg <= IW'(bus.i_Len - 5'd1);
                        end
                        busy_reg  <= 1'b1;
                        state_reg <= LOAD;
                    end else if (bus.i_Replay && valid_reg) begin
                        index_reg <= '0;
                        timer_reg <= ON_LOAD;
                        led_reg   <= led_of(mem[0]);
                        busy_reg  <= 1'b1;
                        state_reg <= SHOW;
                    end
                end

                LOAD: begin
                    lfsr_reg  <= seed_reg;
                    count_reg <= '0;
                    valid_reg <= 1'b0;
                    state_reg <= GEN;
                end

                GEN: begin
                    lfsr_reg  <= lfsr_step(lfsr_reg);
                    count_reg <= count_reg + I_ONE;
                    if (count_reg == len_m1_reg) begin
                        index_reg <= '0;
                        timer_reg <= ON_LOAD;
                        valid_reg <= 1'b1;
                        // For a one-entry pattern, entry 0 is being written
                        // this very cycle, so take it straight from the LFSR.
                        led_reg   <= led_of((count_reg == '0) ? lfsr_reg[1:0] : mem[0]);
                        state_reg <= SHOW;
                    end
                end

                SHOW: begin
                    if (timer_reg == '0) begin
                        timer_reg <= OFF_LOAD;
                        led_reg   <= 4'b0000;
                        state_reg <= GAP;
                    end else begin
                        timer_reg <= timer_reg - T_ONE;
                    end
                end

                GAP: begin
                    if (timer_reg == '0) begin
                        if (index_reg == len_m1_reg) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            index_reg <= index_reg + I_ONE;
                            timer_reg <= ON_LOAD;
                            led_reg   <= led_of(mem[index_reg + I_ONE]);
                            state_reg <= SHOW;
                        end
                    end else begin
                        timer_reg <= timer_reg - T_ONE;
                    end
                end

                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    led_reg   <= 4'b0000;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_Busy   = busy_reg;
    assign bus.o_Led    = led_reg;
    assign bus.o_Number = lfsr_reg;
    assign bus.o_Done   = done_reg;

endmodule
